// File: rtl/seven_seg_scan_n_if.sv
// Display-value and pin bundle for the multiplexed seven-segment scanner.
// The master side produces display data; the slave side is the scanner driving the pins.
interface seven_seg_scan_n_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dots;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [BRIGHT_BITS-1:0]  brightness;
    logic                    load;
    logic [7:0]              segment;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame_done;

    modport master (
        output value, dots, digit_en, blank_lz, brightness, load,
        input  segment, digit, frame_done
    );

    modport slave (
        input  value, dots, digit_en, blank_lz, brightness, load,
        output segment, digit, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment driver with frame-synchronous shadow loading,
// per-digit enable, leading-zero blanking, PWM brightness and selectable pin polarity.
module seven_seg_scan_n #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 50000,
    parameter int BRIGHT_BITS = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input logic clock,
    input logic reset,
    seven_seg_scan_n_if.slave bus
);
    localparam int   IDX_W = $clog2(NUM_DIGITS);
    localparam int   PRE_W = $clog2(CLK_DIV);
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_BITS-1:0]  pwm_cnt;

    logic [4*NUM_DIGITS-1:0] pend_value, act_value;
    logic [NUM_DIGITS-1:0]   pend_dots, act_dots;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic                    pend_blz, act_blz;

    logic                    tick, wrap;
    logic                    run;
    logic [NUM_DIGITS-1:0]   zero_run;
    logic [3:0]              nibble;
    logic                    lit;
    logic [7:0]              next_seg;
    logic [NUM_DIGITS-1:0]   next_dig;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign tick = (prescaler == PRE_W'(CLK_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // zero_run[i]: digits i..MSB all show a bare zero, so digit i may be blanked
    always_comb begin
        run      = 1'b1;
        zero_run = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            run = run && (act_value[4*(NUM_DIGITS-1-k) +: 4] == 4'd0)
                      && !act_dots[NUM_DIGITS-1-k];
            zero_run[NUM_DIGITS-1-k] = run;
        end
    end

    always_comb begin
        nibble   = act_value[{idx, 2'b00} +: 4];
        lit      = act_en[idx] && (pwm_cnt <= bus.brightness)
                   && !(act_blz && (idx != '0) && zero_run[idx]);
        next_seg = '0;
        next_dig = '0;
        if (lit) begin
            next_seg      = {act_dots[idx], decode(nibble)};
            next_dig[idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler      <= '0;
            idx            <= '0;
            pwm_cnt        <= '0;
            pend_value     <= '0;
            pend_dots      <= '0;
            pend_en        <= '0;
            pend_blz       <= 1'b0;
            act_value      <= '0;
            act_dots       <= '0;
            act_en         <= '0;
            act_blz        <= 1'b0;
            bus.segment    <= {8{POL}};
            bus.digit      <= {NUM_DIGITS{POL}};
            bus.frame_done <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (load_fire()) begin
                pend_value <= bus.value;
                pend_dots  <= bus.dots;
                pend_en    <= bus.digit_en;
                pend_blz   <= bus.blank_lz;
            end
            // active takes the pre-edge pending set, so a load on the wrap edge waits a frame
            if (wrap) begin
                act_value <= pend_value;
                act_dots  <= pend_dots;
                act_en    <= pend_en;
                act_blz   <= pend_blz;
            end
            bus.frame_done <= wrap;
            bus.segment    <= next_seg ^ {8{POL}};
            bus.digit      <= next_dig ^ {NUM_DIGITS{POL}};
        end
    end

    function automatic logic load_fire();
        return bus.load;
    endfunction
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Scoreboard bench: stimulus pushes hand-built expected frames tagged with a frame number,
// a monitor collects 16 samples per frame from both polarity variants and compares.
module tb_seven_seg_scan_n;
    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] value;
    logic [3:0]  dots, en, bright;
    logic        blz, load;

    seven_seg_scan_n_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus_hi ();
    seven_seg_scan_n_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus_lo ();

    assign bus_hi.value = value;  assign bus_lo.value = value;
    assign bus_hi.dots = dots;    assign bus_lo.dots = dots;
    assign bus_hi.digit_en = en;  assign bus_lo.digit_en = en;
    assign bus_hi.blank_lz = blz; assign bus_lo.blank_lz = blz;
    assign bus_hi.brightness = bright; assign bus_lo.brightness = bright;
    assign bus_hi.load = load;    assign bus_lo.load = load;

    seven_seg_scan_n #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_BITS(BB), .ACTIVE_LOW(0))
        dut_hi (.clock(clk), .reset(rst), .bus(bus_hi));
    seven_seg_scan_n #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_BITS(BB), .ACTIVE_LOW(1))
        dut_lo (.clock(clk), .reset(rst), .bus(bus_lo));

    typedef struct {
        int unsigned      frame;
        logic [15:0][7:0] seg;
        logic [15:0][3:0] dig;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned stim_frames = 0;
    int unsigned mon_frames = 0;

    // Active-high slot tables (slot 3..0), hand-decoded.
    localparam logic [3:0][7:0] T_12AF = {8'h06, 8'h5B, 8'h77, 8'h71};
    localparam logic [3:0][7:0] T_1234 = {8'h06, 8'h5B, 8'h4F, 8'h66};
    localparam logic [3:0][7:0] T_0050 = {8'h00, 8'h00, 8'h6D, 8'h3F};
    localparam logic [3:0][7:0] T_0050D = {8'hBF, 8'h3F, 8'h6D, 8'h3F};
    localparam logic [3:0][7:0] T_8DP  = {8'h00, 8'h00, 8'h00, 8'hFF};
    localparam logic [3:0][7:0] T_DARK = {8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Frame sample j has pwm_cnt == j and belongs to slot j/4.
    function automatic frame_t make_frame(input int unsigned tgt, input logic [3:0][7:0] slot_seg,
                                          input logic [3:0] slot_on, input logic [3:0] br);
        frame_t f;
        int s;
        f.frame = tgt;
        for (int j = 0; j < 16; j++) begin
            s = j / 4;
            if (slot_on[s] && j <= int'(br)) begin
                f.seg[j] = slot_seg[s];
                f.dig[j] = 4'b0001 << s;
            end else begin
                f.seg[j] = 8'h00;
                f.dig[j] = 4'h0;
            end
        end
        return f;
    endfunction

    task automatic push(input int unsigned ahead, input logic [3:0][7:0] tbl,
                        input logic [3:0] on, input logic [3:0] br);
        exp_q.push_back(make_frame(stim_frames + ahead, tbl, on, br));
    endtask

    task automatic wait_frame_end();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_hi.frame_done && n < 64);
        if (!bus_hi.frame_done) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, expected one within 16", n);
        end else begin
            stim_frames++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                           input logic b);
        value = v; dots = d; en = e; blz = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor
    logic [15:0][7:0] s_hi, s_lo;
    logic [15:0][3:0] d_hi, d_lo;
    int unsigned      nsamp = 0;
    frame_t           f;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            nsamp = 0;
        end else begin
            if (nsamp >= 16) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_len: got more than 16 samples without frame_done, expected 16");
                nsamp = 0;
            end
            s_hi[nsamp] = bus_hi.segment;
            d_hi[nsamp] = bus_hi.digit;
            s_lo[nsamp] = bus_lo.segment;
            d_lo[nsamp] = bus_lo.digit;
            nsamp++;
            if (bus_hi.frame_done || bus_lo.frame_done) begin
                check("frame_done_polarity_match", 32'(bus_lo.frame_done), 32'(bus_hi.frame_done));
                check("frame_period", nsamp, 16);
                mon_frames++;
                while (exp_q.size() > 0 && exp_q[0].frame <= mon_frames) begin
                    f = exp_q.pop_front();
                    if (f.frame < mon_frames) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_missed: got frame %0d, expected frame %0d", mon_frames, f.frame);
                    end else begin
                        for (int j = 0; j < 16; j++) begin
                            check($sformatf("f%0d_s%0d_hi", f.frame, j),
                                  32'({s_hi[j], d_hi[j]}), 32'({f.seg[j], f.dig[j]}));
                            check($sformatf("f%0d_s%0d_lo", f.frame, j),
                                  32'({s_lo[j], d_lo[j]}), 32'({~f.seg[j], ~f.dig[j]}));
                        end
                    end
                end
                nsamp = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        value = '0; dots = '0; en = '0; blz = 1'b0; bright = 4'hF; load = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_seg_hi", 32'(bus_hi.segment), 32'h00);
        check("reset_dig_hi", 32'(bus_hi.digit), 32'h0);
        check("reset_seg_lo", 32'(bus_lo.segment), 32'hFF);
        check("reset_dig_lo", 32'(bus_lo.digit), 32'hF);
        check("reset_frame_done", 32'(bus_hi.frame_done), 32'h0);

        // Basic scan: load applied at the first wrap
        rst = 1'b0;
        push(1, T_DARK, 4'b0000, 4'hF);
        push(2, T_12AF, 4'b1111, 4'hF);
        do_load(16'h12AF, 4'b0000, 4'hF, 1'b0);
        wait_frame_end();
        wait_frame_end();

        // Load coinciding with the wrapping tick lands one frame later
        push(1, T_12AF, 4'b1111, 4'hF);
        repeat (15) @(negedge clk);
        value = 16'h1234; load = 1'b1;
        wait_frame_end();
        load = 1'b0;
        push(1, T_12AF, 4'b1111, 4'hF);
        push(2, T_1234, 4'b1111, 4'hF);
        wait_frame_end();
        wait_frame_end();

        // Leading-zero blanking, then a dot on the MSB stops it
        push(1, T_1234, 4'b1111, 4'hF);
        push(2, T_0050, 4'b0011, 4'hF);
        do_load(16'h0050, 4'b0000, 4'hF, 1'b1);
        wait_frame_end();
        wait_frame_end();
        push(1, T_0050, 4'b0011, 4'hF);
        push(2, T_0050D, 4'b1111, 4'hF);
        do_load(16'h0050, 4'b1000, 4'hF, 1'b1);
        wait_frame_end();
        wait_frame_end();

        // Brightness: sample j is lit only while j <= brightness
        push(1, T_0050D, 4'b1111, 4'hF);
        push(2, T_12AF, 4'b1111, 4'hF);
        do_load(16'h12AF, 4'b0000, 4'hF, 1'b0);
        wait_frame_end();
        wait_frame_end();
        bright = 4'd3; push(1, T_12AF, 4'b1111, 4'd3); wait_frame_end();
        bright = 4'd0; push(1, T_12AF, 4'b1111, 4'd0); wait_frame_end();
        bright = 4'd9; push(1, T_12AF, 4'b1111, 4'd9); wait_frame_end();
        bright = 4'hF;

        // Digit 0 shows 8 with dp, other digits disabled
        push(1, T_12AF, 4'b1111, 4'hF);
        push(2, T_8DP, 4'b0001, 4'hF);
        do_load(16'h0008, 4'b0001, 4'b0001, 1'b0);
        wait_frame_end();
        wait_frame_end();

        // Reset mid-slot while lit; the pending 1234 must be discarded
        do_load(16'h1234, 4'b0000, 4'hF, 1'b0);
        check("pre_reset_lit_dig_hi", 32'(bus_hi.digit), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_seg_hi", 32'(bus_hi.segment), 32'h00);
        check("midreset_dig_hi", 32'(bus_hi.digit), 32'h0);
        check("midreset_seg_lo", 32'(bus_lo.segment), 32'hFF);
        check("midreset_dig_lo", 32'(bus_lo.digit), 32'hF);
        check("midreset_frame_done", 32'(bus_hi.frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        push(1, T_DARK, 4'b0000, 4'hF);
        push(2, T_DARK, 4'b0000, 4'hF);
        wait_frame_end();
        wait_frame_end();

        // Recovery after reset needs a fresh load plus a wrap
        push(1, T_DARK, 4'b0000, 4'hF);
        push(2, T_12AF, 4'b1111, 4'hF);
        do_load(16'h12AF, 4'b0000, 4'hF, 1'b0);
        wait_frame_end();
        wait_frame_end();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
